// File: rtl/shift_add_mult.sv
// rtl/shift_add_mult.sv - sequential unsigned shift-and-add multiplier
//
// Purpose : WIDTH x WIDTH unsigned multiplier, one partial-product step per
//           clock, with a start/busy/done handshake. The multiplicand is
//           accumulated into the upper half of the partial product through
//           a carry-lookahead adder (shift_add_mult_cla).
// Ports   : clk     - rising-edge clock
//           rst_n   - asynchronous active-low reset
//           start   - request, sampled only in IDLE or DONE
//           a, b    - multiplicand / multiplier, captured on accepted start
//           busy    - high in every CALC cycle
//           done    - one-cycle pulse, product valid
//           product - 2*WIDTH result, held until the next result or reset
// Option  : SHIFT_ADD_MULT_EARLY_TERM_EN - finish as soon as the remaining
//           multiplier bits are all zero.

module shift_add_mult_cla #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             cin_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             cout_o
);
   logic [WIDTH-1:0] g;
   logic [WIDTH-1:0] p;
   logic [WIDTH:0]   c;

   assign g = a_i & b_i;
   assign p = a_i ^ b_i;

   // 4-bit lookahead groups; the group carry-in ripples between groups.
   always_comb begin
      c    = '0;
      c[0] = cin_i;
      for (int k = 0; k < WIDTH / 4; k++) begin
         c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
         c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
                  | (p[4*k+1] & p[4*k] & c[4*k]);
         c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                  | (p[4*k+2] & p[4*k+1] & g[4*k])
                  | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
         c[4*k+4] = g[4*k+3] | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
      end
   end

   assign sum_o  = p ^ c[WIDTH-1:0];
   assign cout_o = c[WIDTH];
endmodule

module shift_add_mult #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   state_t             state_q;
   logic [WIDTH-1:0]   mcand_q;
   logic [2*WIDTH-1:0] p_q;
   logic [2*WIDTH-1:0] p_d;
   logic [CNT_W-1:0]   cnt_q;
   logic [2*WIDTH-1:0] product_q;
   logic               busy_q;
   logic               done_q;
   logic               last_d;
   logic [WIDTH-1:0]   add_s;
   logic               add_c;
   logic [2*WIDTH-1:0] step;

`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
   logic [WIDTH-1:0]   shadow_q;
   logic [WIDTH-1:0]   shadow_d;
`endif

   shift_add_mult_cla #(.WIDTH(WIDTH)) u_cla (
      .a_i   (p_q[2*WIDTH-1:WIDTH]),
      .b_i   (mcand_q),
      .cin_i (1'b0),
      .sum_o (add_s),
      .cout_o(add_c)
   );

   // One multiplier bit per step; the adder carry becomes the new top bit.
   assign step = p_q[0] ? {add_c, add_s, p_q[WIDTH-1:1]} : {1'b0, p_q[2*WIDTH-1:1]};

   always_comb begin
      p_d    = step;
      last_d = (cnt_q == LAST);
`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
      shadow_d = shadow_q >> 1;
      // No multiplier bits left: the remaining steps are pure shifts.
      if (shadow_d == '0) begin
         p_d    = step >> (LAST - cnt_q);
         last_d = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         mcand_q   <= '0;
         p_q       <= '0;
         cnt_q     <= '0;
         product_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
         shadow_q  <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  mcand_q  <= a;
                  p_q      <= {{WIDTH{1'b0}}, b};
                  cnt_q    <= '0;
                  busy_q   <= 1'b1;
                  state_q  <= CALC;
`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
                  shadow_q <= b;
`endif
               end else begin
                  state_q <= IDLE;
               end
            end
            CALC: begin
               p_q   <= p_d;
               cnt_q <= cnt_q + CNT_W'(1);
`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
               shadow_q <= shadow_d;
`endif
               if (last_d) begin
                  product_q <= p_d;
                  busy_q    <= 1'b0;
                  done_q    <= 1'b1;
                  state_q   <= DONE;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign product = product_q;
endmodule

// File: tb/tb_shift_add_mult.sv
// tb/tb_shift_add_mult.sv - scoreboard bench for shift_add_mult

module tb_shift_add_mult;
   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] a;
   logic [15:0] b;
   logic        busy;
   logic        done;
   logic [31:0] product;

   typedef struct {
      logic [31:0] prod;
      int          lat;
      int          start_edge;
   } exp_t;

   exp_t        sb[$];
   int          checks;
   int          failures;
   int          cyc;
   int          busy_cnt;

   shift_add_mult #(.WIDTH(16), .CNT_W(5)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .product(product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int model_lat(input logic [15:0] bv);
`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
      int h;
      h = 0;
      for (int i = 0; i < 16; i++) if (bv[i]) h = i + 1;
      return (h == 0) ? 1 : h;
`else
      return 16;
`endif
   endfunction

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents a result.
   always @(negedge clk) begin
      if (!rst_n) begin
         busy_cnt = 0;
      end else begin
         if (busy) busy_cnt++;
         if (done) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_done actual=done required=no_done product=0x%08h", product);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check32("product", product, e.prod);
               check32("latency", 32'(cyc - e.start_edge), 32'(e.lat));
               check32("busy_cycles", 32'(busy_cnt), 32'(e.lat));
               check32("busy_with_done", {31'd0, busy}, 32'd0);
            end
            busy_cnt = 0;
         end
      end
   end

   // Called at a negedge; the next posedge samples start.
   task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input bit push);
      exp_t e;
      a     = ia;
      b     = ib;
      start = 1'b1;
      if (push) begin
         e.prod       = 32'(ia) * 32'(ib);
         e.lat        = model_lat(ib);
         e.start_edge = cyc + 1;
         sb.push_back(e);
      end
      @(negedge clk);
      start = 1'b0;
      a     = 16'($urandom);
      b     = 16'($urandom);
   endtask

   // Returns at the negedge where done is seen.
   task automatic wait_done();
      int n;
      for (n = 0; n < 200; n++) begin
         @(negedge clk);
         if (done) break;
      end
      if (n == 200) begin
         checks++;
         failures++;
         $display("FAIL done_timeout actual=no_done required=done");
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      busy_cnt = 0;
      rst_n    = 1'b0;
      start    = 1'b0;
      a        = '0;
      b        = '0;

      idle(3);
      rst_n = 1'b1;
      idle(1);
      check32("reset_product", product, 32'd0);
      check32("reset_busy", {31'd0, busy}, 32'd0);
      check32("reset_done", {31'd0, done}, 32'd0);
      idle(40);

      issue(16'd3, 16'd5, 1'b1);
      wait_done();
      idle(20);
      check32("hold_product", product, 32'd15);

      issue(16'hFFFF, 16'hFFFF, 1'b1);
      wait_done();
      idle(2);
      issue(16'h8000, 16'h0002, 1'b1);
      wait_done();
      idle(2);

      // A start during CALC must be ignored; then chain in the DONE cycle.
      issue(16'h1234, 16'h0010, 1'b1);
      idle(4);
      a     = 16'd7;
      b     = 16'd7;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done();
      issue(16'h00FF, 16'h00FF, 1'b1);
      wait_done();
      idle(3);

      // Reset in the middle of an operation.
      issue(16'd100, 16'd200, 1'b0);
      idle(7);
      #2 rst_n = 1'b0;
      #1;
      check32("midreset_busy", {31'd0, busy}, 32'd0);
      check32("midreset_product", product, 32'd0);
      check32("midreset_done", {31'd0, done}, 32'd0);
      idle(2);
      rst_n = 1'b1;
      idle(1);
      issue(16'd255, 16'd255, 1'b1);
      wait_done();
      idle(1);

      issue(16'h1234, 16'h0001, 1'b1);
      wait_done();
      idle(1);
      issue(16'h1234, 16'h0000, 1'b1);
      wait_done();
      idle(1);
      issue(16'h1234, 16'h0100, 1'b1);
      wait_done();
      idle(1);
      issue(16'h1234, 16'h8000, 1'b1);
      wait_done();

      // Random operands with random gaps, including back-to-back starts.
      for (int i = 0; i < 40; i++) begin
         logic [15:0] ra;
         logic [15:0] rb;
         ra = 16'($urandom);
         rb = 16'($urandom) >> $urandom_range(0, 15);
         issue(ra, rb, 1'b1);
         wait_done();
         idle($urandom_range(0, 3));
      end

      idle(3);
      if (sb.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
